mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Memory stage of the riscv_cpu pipeline; consumer of the EX/MEM register.
//  - Executes LB/LH/LW/LBU/LHU/SB/SH/SW on a req/gnt/rvalid data-memory bus.
//  - Stalls the pipeline while an access is outstanding.
//  - Aligns and extends load data, and drives the MEM/WB register.
//  - Non-memory ops pass through with one cycle of latency.
// PARAMETERS
//  XLEN      32   datapath width (riscv_pkg value)
//  MAX_WAIT  255  cycles in WAIT_RSP before a bus timeout; 8-bit counter
// PORTS
//  clk_i           in   1     clock
//  rstn_i          in   1     asynchronous, active-low reset
//  tb_update_i     in   1     testbench retire marker from EX/MEM
//  pcM_i/instrM_i  in   XLEN  PC and instruction from EX/MEM
//  operationM_i    in   alu_ctrl_e  decoded op
//  memM_addr_i     in   XLEN  effective byte address
//  memM_wr_data_i  in   XLEN  store data (rs2)
//  memM_wr_ena_i   in   1     store enable
//  rdM_data_i      in   XLEN  ALU result
//  rdM_addr_i      in   5     rd address
//  rdM_wr_ena_i    in   1     rd write enable
//  dmem_req_o      out  1     bus request
//  dmem_gnt_i      in   1     request accepted
//  dmem_we_o       out  1     1 = write
//  dmem_addr_o     out  XLEN  word address {addr[XLEN-1:2],2'b00}
//  dmem_be_o       out  4     byte enables
//  dmem_wdata_o    out  XLEN  lane-shifted store data
//  dmem_rvalid_i   in   1     response/ack, one cycle per granted request
//  dmem_rdata_i    in   XLEN  read data
//  stall_o         out  1     freeze IF..EX/MEM
//  bus_err_o       out  1     1-cycle pulse on timeout
//  misalign_o      out  1     1-cycle pulse (only with LSU_MISALIGN_EXC_EN)
//  pcW_o,instrW_o,rdW_data_o,rdW_addr_o,rdW_wr_ena_o,tb_update_o  out  MEM/WB register
// BEHAVIOUR
//  - FSM lsu_state_e: IDLE, WAIT_RSP.
//  - Reset (async): state IDLE, counter 0, all bus/stall/err outputs 0.
//    MEM/WB register resets to pcW 'h8000_0000, instrW 'h13, remaining fields 0.
//  - IDLE, non-memory op: stall_o=0; MEM/WB captures inputs at the next edge.
//  - IDLE, load/store:
//    - dmem_req_o=1 and stall_o=1 combinationally.
//    - Request fields stay stable until dmem_gnt_i.
//    - On gnt: go to WAIT_RSP and clear the counter.
//  - WAIT_RSP:
//    - req=0, stall_o=1; counter++ each cycle.
//    - On rvalid: stall_o=0 in that cycle; MEM/WB captures the result; go to IDLE.
//    - If counter==MAX_WAIT with no rvalid: bus_err_o pulses; complete with data 0 and rd write suppressed; go to IDLE.
//  - Stalled cycles insert a bubble into MEM/WB: rdW_wr_ena_o=0, tb_update_o=0.
//  - Best case: load/store occupies 2 cycles (gnt in cycle 0, rvalid in cycle 1).
//  - Byte enables, with o = addr[1:0]:
//    - byte: 4'b0001<<o
//    - half: 4'b0011<<o
//    - word: 4'b1111
//    - Store data is shifted left by 8*o. Bits shifted beyond lane 3 are dropped.
//  - Loads: rdata>>8*o, then LB/LH sign-extend and LBU/LHU zero-extend. Write to rd only if rdM_wr_ena_i and rdM_addr_i!=0.
//  - rvalid/gnt seen in IDLE with no request pending are ignored, e.g. a stale response after reset.
//  - Reset mid-access drops the request immediately; no MEM/WB update occurs.
// CONFIGURATION
//  LSU_MISALIGN_EXC_EN defined:
//    - Misaligned LH/LHU/SH (addr[0]) or LW/SW (addr[1:0]!=0) issues no bus request.
//    - The access completes in 1 cycle without stall: misalign_o pulses, rd write suppressed.
//  Not defined: misaligned accesses are issued using the lane-truncation rule above; misalign_o tied 0.
// STRUCTURE
//  - Additions to riscv_pkg: lsu_state_e; mem_size_e {MS_B,MS_H,MS_W}; function is_mem_op(alu_ctrl_e).
//  - Sub-module lsu_load_align (combinational): rdata, offset, size, unsigned -> load result. Also produces store be/wdata.
//  - FSM, timeout counter and MEM/WB register live in mem_stage_lsu.
// TESTING
//  1. ADD, rdM_data_i=5, rd=3 -> next edge rdW_data=5, rdW_wr_ena=1; no req, stall_o=0 throughout.
//  2. LB addr 0x..01, rdata 0x0000_8000 -> be=0001<<1=0010 on bus; rdW_data=0xFFFF_FF80.
//     LBU with the same rdata -> rdW_data=0x80.
//  3. SH addr 0x..02, wdata 0x1234 -> be=1100, wdata 0x1234_0000, we=1.
//     gnt delayed 3 cycles -> req and stall_o held; MEM/WB bubbles.
//  4. LW with no rvalid for MAX_WAIT cycles -> bus_err_o 1 cycle, rdW_wr_ena=0, state IDLE.
//  5. rstn_i low while in WAIT_RSP -> req/stall 0 immediately. A late rvalid after reset leaves MEM/WB at its reset value.
//  6. LSU_MISALIGN_EXC_EN: LW addr 0x..02 -> no req, misalign_o=1, rdW_wr_ena=0.
//     Without the macro: be=1100, load result = rdata>>16.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared riscv_cpu types plus the load/store unit additions
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC, ALU_JAL, ALU_JALR,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW
  } alu_ctrl_e;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } lsu_state_e;

  typedef enum logic [1:0] {
    MS_B,
    MS_H,
    MS_W
  } mem_size_e;

  function automatic logic is_mem_op(alu_ctrl_e op);
    return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic mem_size_e mem_size(alu_ctrl_e op);
    mem_size_e sz;
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: sz = MS_B;
      ALU_LH, ALU_LHU, ALU_SH: sz = MS_H;
      default:                 sz = MS_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_unsigned_load(alu_ctrl_e op);
    return op inside {ALU_LBU, ALU_LHU};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - byte-lane alignment: load shift/extend, store byte enables and data
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_data_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [3:0]      be_mask;
  logic [7:0]      be_wide;

  always_comb begin
    shamt       = {offset_i, 3'b000};
    shifted     = rdata_i >> shamt;
    wdata_o     = wdata_i << shamt;
    load_data_o = shifted;
    be_mask     = 4'b1111;
    case (size_i)
      MS_B: begin
        be_mask     = 4'b0001;
        load_data_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      MS_H: begin
        be_mask     = 4'b0011;
        load_data_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    // Lanes pushed past byte 3 fall off the top of the 4-bit enable.
    be_wide = {4'b0000, be_mask} << offset_i;
    be_o    = be_wide[3:0];
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage: req/gnt/rvalid load/store FSM, bus timeout, MEM/WB register
// Optional: LSU_MISALIGN_EXC_EN turns misaligned halfword/word accesses into a local exception.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            tb_update_i,
  input  logic [XLEN-1:0] pcM_i,
  input  logic [XLEN-1:0] instrM_i,
  input  alu_ctrl_e       operationM_i,
  input  logic [XLEN-1:0] memM_addr_i,
  input  logic [XLEN-1:0] memM_wr_data_i,
  input  logic            memM_wr_ena_i,
  input  logic [XLEN-1:0] rdM_data_i,
  input  logic [4:0]      rdM_addr_i,
  input  logic            rdM_wr_ena_i,
  output logic            dmem_req_o,
  input  logic            dmem_gnt_i,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            bus_err_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] pcW_o,
  output logic [XLEN-1:0] instrW_o,
  output logic [XLEN-1:0] rdW_data_o,
  output logic [4:0]      rdW_addr_o,
  output logic            rdW_wr_ena_o,
  output logic            tb_update_o
);

  lsu_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_w_q, pc_w_d;
  logic [XLEN-1:0] instr_w_q, instr_w_d;
  logic [XLEN-1:0] rd_data_w_q, rd_data_w_d;
  logic [4:0]      rd_addr_w_q, rd_addr_w_d;
  logic            rd_wr_ena_w_q, rd_wr_ena_w_d;
  logic            tb_update_w_q, tb_update_w_d;

  logic            mem_op;
  mem_size_e       size;
  logic            misaligned;
  logic            req, stall, bus_err, misalign, suppress;
  logic [XLEN-1:0] load_data;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;

  assign mem_op = is_mem_op(operationM_i);
  assign size   = mem_size(operationM_i);

`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned = mem_op && (((size == MS_H) && memM_addr_i[0]) ||
                                 ((size == MS_W) && (memM_addr_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  lsu_load_align u_align (
    .rdata_i     (dmem_rdata_i),
    .offset_i    (memM_addr_i[1:0]),
    .size_i      (size),
    .unsigned_i  (is_unsigned_load(operationM_i)),
    .wdata_i     (memM_wr_data_i),
    .load_data_o (load_data),
    .be_o        (be),
    .wdata_o     (wdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    stall    = 1'b0;
    bus_err  = 1'b0;
    misalign = 1'b0;
    suppress = 1'b0;
    case (state_q)
      IDLE: begin
        if (misaligned) begin
          misalign = 1'b1;
          suppress = 1'b1;
        end else if (mem_op) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem_gnt_i) begin
            state_d = WAIT_RSP;
            cnt_d   = 8'd0;
          end
        end
      end
      WAIT_RSP: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (dmem_rvalid_i) begin
          stall   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 8'(MAX_WAIT)) begin
          stall    = 1'b0;
          bus_err  = 1'b1;
          suppress = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A held-in-reset stage must not present a request even if EX/MEM still shows a load.
  assign dmem_req_o   = req && rstn_i;
  assign stall_o      = stall && rstn_i;
  assign bus_err_o    = bus_err && rstn_i;
  assign misalign_o   = misalign && rstn_i;
  assign dmem_we_o    = dmem_req_o && memM_wr_ena_i;
  assign dmem_addr_o  = dmem_req_o ? {memM_addr_i[XLEN-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
  assign dmem_wdata_o = (dmem_req_o && memM_wr_ena_i) ? wdata : '0;

  always_comb begin
    pc_w_d        = pc_w_q;
    instr_w_d     = instr_w_q;
    rd_data_w_d   = rd_data_w_q;
    rd_addr_w_d   = rd_addr_w_q;
    rd_wr_ena_w_d = 1'b0;
    tb_update_w_d = 1'b0;
    if (!stall) begin
      pc_w_d        = pcM_i;
      instr_w_d     = instrM_i;
      rd_addr_w_d   = rdM_addr_i;
      tb_update_w_d = tb_update_i;
      if (!mem_op) begin
        rd_data_w_d   = rdM_data_i;
        rd_wr_ena_w_d = rdM_wr_ena_i;
      end else begin
        rd_data_w_d   = (suppress || memM_wr_ena_i) ? '0 : load_data;
        rd_wr_ena_w_d = !suppress && !memM_wr_ena_i && rdM_wr_ena_i && (rdM_addr_i != 5'd0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      pc_w_q        <= 32'h8000_0000;
      instr_w_q     <= 32'h0000_0013;
      rd_data_w_q   <= '0;
      rd_addr_w_q   <= 5'd0;
      rd_wr_ena_w_q <= 1'b0;
      tb_update_w_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_w_q        <= pc_w_d;
      instr_w_q     <= instr_w_d;
      rd_data_w_q   <= rd_data_w_d;
      rd_addr_w_q   <= rd_addr_w_d;
      rd_wr_ena_w_q <= rd_wr_ena_w_d;
      tb_update_w_q <= tb_update_w_d;
    end
  end

  assign pcW_o        = pc_w_q;
  assign instrW_o     = instr_w_q;
  assign rdW_data_o   = rd_data_w_q;
  assign rdW_addr_o   = rd_addr_w_q;
  assign rdW_wr_ena_o = rd_wr_ena_w_q;
  assign tb_update_o  = tb_update_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        tb_update_i;
  logic [31:0] pcM_i, instrM_i;
  alu_ctrl_e   operationM_i;
  logic [31:0] memM_addr_i, memM_wr_data_i;
  logic        memM_wr_ena_i;
  logic [31:0] rdM_data_i;
  logic [4:0]  rdM_addr_i;
  logic        rdM_wr_ena_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o, bus_err_o, misalign_o;
  logic [31:0] pcW_o, instrW_o, rdW_data_o;
  logic [4:0]  rdW_addr_o;
  logic        rdW_wr_ena_o, tb_update_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_stage_lsu #(.MAX_WAIT(255)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .tb_update_i(tb_update_i),
    .pcM_i(pcM_i), .instrM_i(instrM_i), .operationM_i(operationM_i),
    .memM_addr_i(memM_addr_i), .memM_wr_data_i(memM_wr_data_i), .memM_wr_ena_i(memM_wr_ena_i),
    .rdM_data_i(rdM_data_i), .rdM_addr_i(rdM_addr_i), .rdM_wr_ena_i(rdM_wr_ena_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o),
    .pcW_o(pcW_o), .instrW_o(instrW_o), .rdW_data_o(rdW_data_o),
    .rdW_addr_o(rdW_addr_o), .rdW_wr_ena_o(rdW_wr_ena_o), .tb_update_o(tb_update_o)
  );

  task automatic set_op(input alu_ctrl_e op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdd, input logic [4:0] rd, input logic rd_we,
                        input logic st);
    operationM_i   = op;
    memM_addr_i    = addr;
    memM_wr_data_i = wd;
    memM_wr_ena_i  = st;
    rdM_data_i     = rdd;
    rdM_addr_i     = rd;
    rdM_wr_ena_i   = rd_we;
    pcM_i          = 32'h0000_0100 + addr;
    instrM_i       = 32'h0000_0003;
    tb_update_i    = 1'b1;
  endtask

  task automatic set_nop();
    set_op(ALU_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    instrM_i    = 32'h0000_0013;
    tb_update_i = 1'b0;
  endtask

  // Grant in the first cycle, respond in the second; returns just after the completing edge.
  task automatic bus_xact(input logic [31:0] rdata);
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    set_op(ALU_LW, 32'h10, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
    repeat (2) @(posedge clk_i); #1;
    checks++; if (pcW_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_pcW got %h want 80000000", pcW_o); end
    checks++; if (instrW_o !== 32'h13) begin errors++; $display("FAIL reset_instrW got %h want 00000013", instrW_o); end
    checks++; if ({rdW_data_o, rdW_addr_o, rdW_wr_ena_o, tb_update_o} !== 39'h0) begin errors++;
      $display("FAIL reset_memwb got data=%h rd=%0d we=%b tb=%b want zeros", rdW_data_o, rdW_addr_o, rdW_wr_ena_o, tb_update_o); end
    checks++; if ({dmem_req_o, stall_o, bus_err_o, misalign_o, dmem_be_o} !== 8'h0) begin errors++;
      $display("FAIL reset_bus got req=%b stall=%b err=%b mis=%b be=%b want 0", dmem_req_o, stall_o, bus_err_o, misalign_o, dmem_be_o); end
    set_nop();
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_alu();
    set_op(ALU_ADD, 32'h0, 32'h0, 32'd5, 5'd3, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++; if ({dmem_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL alu_nostall got req=%b stall=%b want 00", dmem_req_o, stall_o); end
    @(posedge clk_i); #1;
    checks++; if ({rdW_data_o, rdW_addr_o, rdW_wr_ena_o, tb_update_o} !== {32'd5, 5'd3, 1'b1, 1'b1}) begin errors++;
      $display("FAIL alu_memwb got data=%h rd=%0d we=%b tb=%b want 5/3/1/1", rdW_data_o, rdW_addr_o, rdW_wr_ena_o, tb_update_o); end
  endtask

  task automatic test_load_ext();
    set_op(ALU_LB, 32'h0000_1001, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if ({dmem_req_o, stall_o, dmem_we_o, dmem_be_o, dmem_addr_o} !== {3'b110, 4'b0010, 32'h0000_1000}) begin errors++;
      $display("FAIL lb_req got req=%b stall=%b we=%b be=%b addr=%h want 1/1/0/0010/00001000", dmem_req_o, stall_o, dmem_we_o, dmem_be_o, dmem_addr_o); end
    @(posedge clk_i); #1;
    checks++; if ({rdW_wr_ena_o, tb_update_o} !== 2'b00) begin errors++; $display("FAIL lb_bubble got we=%b tb=%b want 00", rdW_wr_ena_o, tb_update_o); end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_8000;
    @(negedge clk_i);
    checks++; if ({dmem_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL lb_rsp_stall got req=%b stall=%b want 00", dmem_req_o, stall_o); end
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    checks++; if ({rdW_data_o, rdW_wr_ena_o, rdW_addr_o} !== {32'hFFFF_FF80, 1'b1, 5'd5}) begin errors++;
      $display("FAIL lb_data got %h we=%b rd=%0d want ffffff80/1/5", rdW_data_o, rdW_wr_ena_o, rdW_addr_o); end
    set_op(ALU_LBU, 32'h0000_1001, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
    bus_xact(32'h0000_8000);
    checks++; if ({rdW_data_o, rdW_wr_ena_o} !== {32'h0000_0080, 1'b1}) begin errors++;
      $display("FAIL lbu_data got %h we=%b want 00000080/1", rdW_data_o, rdW_wr_ena_o); end
    set_op(ALU_LBU, 32'h0000_1001, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    bus_xact(32'h0000_8000);
    checks++; if ({rdW_wr_ena_o, tb_update_o} !== 2'b01) begin errors++; $display("FAIL load_rd0 got we=%b tb=%b want 0/1", rdW_wr_ena_o, tb_update_o); end
  endtask

  task automatic test_store_delay();
    set_op(ALU_SH, 32'h0000_2002, 32'h0000_1234, 32'h0, 5'd0, 1'b0, 1'b1);
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if ({dmem_req_o, stall_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o} !== {3'b111, 4'b1100, 32'h1234_0000, 32'h0000_2000}) begin errors++;
        $display("FAIL sh_hold%0d got req=%b stall=%b we=%b be=%b wd=%h addr=%h", i, dmem_req_o, stall_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o); end
      @(posedge clk_i); #1;
      checks++; if ({rdW_wr_ena_o, tb_update_o} !== 2'b00) begin errors++; $display("FAIL sh_bubble%0d got we=%b tb=%b want 00", i, rdW_wr_ena_o, tb_update_o); end
    end
    bus_xact(32'h0);
    checks++; if ({rdW_wr_ena_o, tb_update_o} !== 2'b01) begin errors++; $display("FAIL sh_done got we=%b tb=%b want 0/1", rdW_wr_ena_o, tb_update_o); end
  endtask

  task automatic test_back_to_back();
    set_op(ALU_SB, 32'h0000_6003, 32'h0000_00AB, 32'h0, 5'd0, 1'b0, 1'b1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if ({dmem_be_o, dmem_wdata_o} !== {4'b1000, 32'hAB00_0000}) begin errors++;
      $display("FAIL sb_lane got be=%b wd=%h want 1000/ab000000", dmem_be_o, dmem_wdata_o); end
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    set_op(ALU_LH, 32'h0000_6002, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++; if ({dmem_req_o, dmem_be_o} !== {1'b1, 4'b1100}) begin errors++; $display("FAIL lh_issue got req=%b be=%b want 1/1100", dmem_req_o, dmem_be_o); end
    @(posedge clk_i); #1;
    bus_xact(32'h8001_0000);
    checks++; if ({rdW_data_o, rdW_wr_ena_o} !== {32'hFFFF_8001, 1'b1}) begin errors++;
      $display("FAIL lh_data got %h we=%b want ffff8001/1", rdW_data_o, rdW_wr_ena_o); end
  endtask

  task automatic test_timeout();
    int k_err;
    bit early_drop;
    k_err = -1; early_drop = 1'b0;
    set_op(ALU_LW, 32'h0000_3000, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0);
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (bus_err_o) begin k_err = k; break; end
      if (!stall_o || dmem_req_o) early_drop = 1'b1;
      @(posedge clk_i); #1;
    end
    checks++; if (k_err != 255) begin errors++; $display("FAIL timeout_cycle got %0d want 255", k_err); end
    checks++; if (early_drop || stall_o !== 1'b0) begin errors++; $display("FAIL timeout_stall got early_drop=%b stall=%b want 0/0", early_drop, stall_o); end
    @(posedge clk_i); #1;
    checks++; if ({rdW_data_o, rdW_wr_ena_o, tb_update_o} !== {32'h0, 1'b0, 1'b1}) begin errors++;
      $display("FAIL timeout_memwb got data=%h we=%b tb=%b want 0/0/1", rdW_data_o, rdW_wr_ena_o, tb_update_o); end
    set_nop();
    @(negedge clk_i);
    checks++; if ({bus_err_o, stall_o} !== 2'b00) begin errors++; $display("FAIL timeout_idle got err=%b stall=%b want 00", bus_err_o, stall_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    set_op(ALU_LW, 32'h0000_4000, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0);
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    checks++; if ({dmem_req_o, stall_o} !== 2'b00) begin errors++; $display("FAIL rst_mid_bus got req=%b stall=%b want 00", dmem_req_o, stall_o); end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_FFFF;
    @(posedge clk_i); #1;
    checks++; if ({pcW_o, instrW_o, rdW_data_o, rdW_wr_ena_o, tb_update_o} !== {32'h8000_0000, 32'h13, 32'h0, 2'b00}) begin errors++;
      $display("FAIL rst_mid_memwb got pc=%h instr=%h data=%h we=%b tb=%b", pcW_o, instrW_o, rdW_data_o, rdW_wr_ena_o, tb_update_o); end
    rstn_i = 1'b1;
    set_op(ALU_LW, 32'h0000_4004, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++; if ({dmem_req_o, stall_o} !== 2'b11) begin errors++; $display("FAIL stale_rvalid_stall got req=%b stall=%b want 11", dmem_req_o, stall_o); end
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    checks++; if (tb_update_o !== 1'b0) begin errors++; $display("FAIL stale_rvalid_memwb got tb=%b want 0", tb_update_o); end
    bus_xact(32'h1234_5678);
    checks++; if ({rdW_data_o, rdW_wr_ena_o} !== {32'h1234_5678, 1'b1}) begin errors++;
      $display("FAIL post_reset_lw got %h we=%b want 12345678/1", rdW_data_o, rdW_wr_ena_o); end
  endtask

  task automatic test_misalign();
    set_op(ALU_LW, 32'h0000_5002, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0);
`ifdef LSU_MISALIGN_EXC_EN
    @(negedge clk_i);
    checks++; if ({dmem_req_o, stall_o, misalign_o} !== 3'b001) begin errors++;
      $display("FAIL mis_exc got req=%b stall=%b mis=%b want 0/0/1", dmem_req_o, stall_o, misalign_o); end
    @(posedge clk_i); #1;
    checks++; if ({rdW_wr_ena_o, tb_update_o} !== 2'b01) begin errors++; $display("FAIL mis_memwb got we=%b tb=%b want 0/1", rdW_wr_ena_o, tb_update_o); end
`else
    @(negedge clk_i);
    checks++; if ({dmem_req_o, dmem_be_o, misalign_o} !== {1'b1, 4'b1100, 1'b0}) begin errors++;
      $display("FAIL mis_issue got req=%b be=%b mis=%b want 1/1100/0", dmem_req_o, dmem_be_o, misalign_o); end
    @(posedge clk_i); #1;
    bus_xact(32'hDEAD_BEEF);
    checks++; if ({rdW_data_o, rdW_wr_ena_o} !== {32'h0000_DEAD, 1'b1}) begin errors++;
      $display("FAIL mis_data got %h we=%b want 0000dead/1", rdW_data_o, rdW_wr_ena_o); end
`endif
    set_nop();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ext();
    test_store_delay();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misalign();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
